// File: rtl/bus_pkg.sv
// Shared constants and helpers for the bus address decoder slice.
// Default windows match the memory and factorial-core map.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 32;
  localparam int MAX_S      = 8;

  localparam logic [15:0] MEM_BASE = 16'h0000;
  localparam logic [15:0] MEM_LAST = 16'h07FF;
  localparam logic [15:0] FAC_BASE = 16'h7000;
  localparam logic [15:0] FAC_LAST = 16'h71FF;

  // Keep only the lowest set bit: lowest slave index wins on overlap
  function automatic logic [MAX_S-1:0] onehot_first(
    input logic [MAX_S-1:0] v
  );
    return v & (~v + MAX_S'(1));
  endfunction

endpackage

// File: rtl/bus_rdata_mux.sv
// One-hot read-data mux over NUM_S packed slave slots.
// Output is all zeros when no slot is selected.
module bus_rdata_mux
  import bus_pkg::*;
#(
  parameter int NUM_S  = 2,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic [NUM_S-1:0]        sel_i,
  input  logic [NUM_S*DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (sel_i[i]) begin
        data_o = data_o | data_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/bus_addr_decoder.sv
// Parametrised bus address decoder with registered data phase.
// Optional saturating error counter: BUS_DECODER_ERR_CNT_EN.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int NUM_S  = 2,
  parameter logic [NUM_S*ADDR_W-1:0] S_BASE = {FAC_BASE, MEM_BASE},
  parameter logic [NUM_S*ADDR_W-1:0] S_LAST = {FAC_LAST, MEM_LAST}
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    m_req,
  input  logic [ADDR_W-1:0]       m_addr,
  output logic [NUM_S-1:0]        s_sel,
  input  logic [NUM_S*DATA_W-1:0] s_rdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_rvalid,
  output logic                    m_err,
  output logic                    err_valid,
  output logic [ADDR_W-1:0]       err_addr,
  input  logic                    err_clr
`ifdef BUS_DECODER_ERR_CNT_EN
  ,
  output logic [15:0]             err_cnt
`endif
);

  logic [MAX_S-1:0]  hit;
  logic [MAX_S-1:0]  sel_first;
  logic              any_hit;
  logic              unused_sel;

  logic [NUM_S-1:0]  dp_sel_q, dp_sel_d;
  logic              dp_err_q, dp_err_d;
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // Inclusive window compare; inverted windows simply never hit
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_S; i++) begin
      hit[i] = m_req
        && (m_addr >= S_BASE[i*ADDR_W +: ADDR_W])
        && (m_addr <= S_LAST[i*ADDR_W +: ADDR_W]);
    end
  end

  assign sel_first  = onehot_first(hit);
  assign any_hit    = |hit;
  assign unused_sel = ^sel_first;
  assign s_sel      = reset_n ? sel_first[NUM_S-1:0] : '0;

  assign dp_sel_d  = s_sel;
  assign dp_err_d  = m_req & ~any_hit;
  assign dp_addr_d = m_addr;

  // Clear beats capture; only the first error is held
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (err_clr) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
    end else if (dp_err_q && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_addr_d  = dp_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dp_sel_q    <= '0;
      dp_err_q    <= 1'b0;
      dp_addr_q   <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      dp_sel_q    <= dp_sel_d;
      dp_err_q    <= dp_err_d;
      dp_addr_q   <= dp_addr_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  bus_rdata_mux #(
    .NUM_S  (NUM_S),
    .DATA_W (DATA_W)
  ) u_rdata_mux (
    .sel_i  (dp_sel_q),
    .data_i (s_rdata),
    .data_o (m_rdata)
  );

  assign m_rvalid  = |dp_sel_q;
  assign m_err     = dp_err_q;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

`ifdef BUS_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (dp_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Self-checking bench for bus_addr_decoder: vector table,
// directed corner sequences and randomized traffic vs a model.
module tb_bus_addr_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_req;
  logic [15:0] m_addr;
  logic [1:0]  s_sel;
  logic [63:0] s_rdata;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_err;
  logic        err_valid;
  logic [15:0] err_addr;
  logic        err_clr;

  logic        m2_req;
  logic [15:0] m2_addr;
  logic [2:0]  s2_sel;
  logic [95:0] s2_rdata;
  logic [31:0] m2_rdata;
  logic        m2_rvalid;
  logic        m2_err;
  logic        e2_valid;
  logic [15:0] e2_addr;

`ifdef BUS_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [15:0] e2_cnt;
`endif

  always #5 clk = ~clk;

  bus_addr_decoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .s_sel     (s_sel),
    .s_rdata   (s_rdata),
    .m_rdata   (m_rdata),
    .m_rvalid  (m_rvalid),
    .m_err     (m_err),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
`ifdef BUS_DECODER_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  bus_addr_decoder #(
    .NUM_S  (3),
    .S_BASE ({16'h2000, 16'h0800, 16'h0000}),
    .S_LAST ({16'h1FFF, 16'h08FF, 16'h0FFF})
  ) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_req     (m2_req),
    .m_addr    (m2_addr),
    .s_sel     (s2_sel),
    .s_rdata   (s2_rdata),
    .m_rdata   (m2_rdata),
    .m_rvalid  (m2_rvalid),
    .m_err     (m2_err),
    .err_valid (e2_valid),
    .err_addr  (e2_addr),
    .err_clr   (1'b0)
`ifdef BUS_DECODER_ERR_CNT_EN
    ,
    .err_cnt   (e2_cnt)
`endif
  );

  int nvec = 0;
  int nmis = 0;

  // Reference model state (what should be visible this cycle)
  int          pend_idx = -1;
  bit          pend_err = 0;
  logic [15:0] pend_addr = '0;
  bit          mdl_ev = 0;
  logic [15:0] mdl_ea = '0;
  int          mdl_cnt = 0;

  logic [1:0]  last_sel;
  logic [31:0] last_rdata;
  logic        last_rvalid, last_err, last_ev;
  logic [15:0] last_ea;

  int unsigned win_base [2] = '{32'h0000, 32'h7000};
  int unsigned win_last [2] = '{32'h07FF, 32'h71FF};

  typedef struct {
    bit          req;
    logic [15:0] addr;
    logic [1:0]  sel;
    bit          err;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic int ref_idx(input logic [15:0] a);
    for (int i = 0; i < 2; i++)
      if (int'(a) >= win_base[i] && int'(a) <= win_last[i])
        return i;
    return -1;
  endfunction

  task automatic cyc(input bit rst, input bit req,
                     input logic [15:0] a, input bit clr,
                     input logic [63:0] rd);
    int idx;
    logic [31:0] exp_rd;
    reset_n = rst; m_req = req; m_addr = a;
    err_clr = clr; s_rdata = rd;
    #1;
    idx = ref_idx(a);
    chk("s_sel", s_sel,
        (rst && req && idx >= 0) ? 64'(1 << idx) : 64'd0);
    exp_rd = (pend_idx >= 0) ? rd[pend_idx*32 +: 32] : 32'd0;
    chk("m_rvalid", m_rvalid, pend_idx >= 0);
    chk("m_rdata", m_rdata, exp_rd);
    chk("m_err", m_err, pend_err);
    chk("err_valid", err_valid, mdl_ev);
    chk("err_addr", err_addr, mdl_ea);
`ifdef BUS_DECODER_ERR_CNT_EN
    chk("err_cnt", err_cnt, mdl_cnt);
`endif
    last_sel = s_sel; last_rdata = m_rdata;
    last_rvalid = m_rvalid; last_err = m_err;
    last_ev = err_valid; last_ea = err_addr;
    if (!rst) begin
      mdl_ev = 0; mdl_ea = '0; mdl_cnt = 0;
      pend_idx = -1; pend_err = 0; pend_addr = '0;
    end else begin
      if (clr) begin
        mdl_ev = 0; mdl_ea = '0; mdl_cnt = 0;
      end else begin
        if (pend_err && !mdl_ev) begin
          mdl_ev = 1; mdl_ea = pend_addr;
        end
        if (pend_err && mdl_cnt < 65535) mdl_cnt++;
      end
      pend_idx  = (req && idx >= 0) ? idx : -1;
      pend_err  = req && idx < 0;
      pend_addr = a;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  vec_t tbl [9];
  logic [15:0] edges [8] = '{16'h07FF, 16'h0800, 16'h7000,
    16'h71FF, 16'h7200, 16'h6FFF, 16'h0000, 16'hFFFF};

  initial begin
    tbl[0] = '{1, 16'h07FF, 2'b01, 0};
    tbl[1] = '{1, 16'h0800, 2'b00, 1};
    tbl[2] = '{1, 16'h7000, 2'b10, 0};
    tbl[3] = '{1, 16'h71FF, 2'b10, 0};
    tbl[4] = '{1, 16'h7200, 2'b00, 1};
    tbl[5] = '{1, 16'h0000, 2'b01, 0};
    tbl[6] = '{1, 16'h6FFF, 2'b00, 1};
    tbl[7] = '{0, 16'h7000, 2'b00, 0};
    tbl[8] = '{1, 16'hFFFF, 2'b00, 1};

    reset_n = 0; m_req = 0; m_addr = '0;
    err_clr = 0; s_rdata = '0;
    m2_req = 0; m2_addr = '0; s2_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with an active request
    cyc(0, 1, 16'h0010, 0, rnd64());
    chk("rst_sel", last_sel, 2'b00);
    cyc(0, 1, 16'h0010, 0, rnd64());
    cyc(1, 0, 16'h0010, 0, rnd64());
    chk("rst_rel_rvalid", last_rvalid, 0);
    chk("rst_rel_err", last_err, 0);
    chk("rst_rel_ev", last_ev, 0);

    // Window edge table
    for (int i = 0; i < 9; i++) begin
      cyc(1, tbl[i].req, tbl[i].addr, 0, rnd64());
      chk("tbl_sel", last_sel, tbl[i].sel);
      if (i > 0) chk("tbl_err", last_err, tbl[i-1].err);
    end
    cyc(1, 0, 16'h0000, 0, rnd64());
    chk("tbl_err", last_err, tbl[8].err);
    cyc(1, 0, 16'h0000, 1, rnd64());

    // Read return, back-to-back without bubble
    cyc(1, 1, 16'h7004, 0, rnd64());
    cyc(1, 1, 16'h0004, 0, {32'h0000_0078, 32'h0BAD_0BAD});
    chk("rd_fac", last_rdata, 32'h78);
    chk("rd_fac_v", last_rvalid, 1);
    cyc(1, 0, 16'h0000, 0, {32'h0BAD_0BAD, 32'hCAFE_0004});
    chk("rd_mem", last_rdata, 32'hCAFE_0004);
    chk("rd_mem_v", last_rvalid, 1);

    // First unmapped address is held
    cyc(1, 1, 16'h1234, 0, rnd64());
    cyc(1, 1, 16'h5678, 0, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    chk("cap_ev", last_ev, 1);
    chk("cap_ea", last_ea, 16'h1234);
    cyc(1, 0, 16'h0000, 1, rnd64());
    cyc(1, 1, 16'h3000, 0, rnd64());
    cyc(1, 0, 16'h0000, 1, rnd64());
    chk("clr_err_pulse", last_err, 1);
    cyc(1, 0, 16'h0000, 0, rnd64());
    chk("clr_wins_ev", last_ev, 0);

    // Reset during an access discards the data phase
    cyc(1, 1, 16'h0004, 0, rnd64());
    cyc(0, 1, 16'h1234, 0, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    chk("midrst_rvalid", last_rvalid, 0);
    chk("midrst_err", last_err, 0);

    // Overlapping windows, three slaves
    m2_req = 1; m2_addr = 16'h0850; #1;
    chk("ovl_sel", s2_sel, 3'b001);
    @(posedge clk); #1;
    s2_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    m2_addr = 16'h2000; #1;
    chk("ovl_rdata", m2_rdata, 32'h1111_1111);
    chk("ovl_rvalid", m2_rvalid, 1);
    chk("inv_sel", s2_sel, 3'b000);
    @(posedge clk); #1;
    m2_addr = 16'h08FF; #1;
    chk("inv_err", m2_err, 1);
    chk("ovl_edge_sel", s2_sel, 3'b001);
    @(posedge clk); #1;
    m2_req = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 1) == 0) ? 16'($urandom)
        : edges[$urandom_range(0, 7)];
      cyc(1, $urandom_range(0, 3) != 0, a,
          $urandom_range(0, 15) == 0, rnd64());
    end

`ifdef BUS_DECODER_ERR_CNT_EN
    cyc(1, 0, 16'h0000, 1, rnd64());
    repeat (3) cyc(1, 1, 16'h1234, 0, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    chk("cnt3", err_cnt, 16'd3);
    repeat (65540) cyc(1, 1, 16'h9000, 0, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    chk("cnt_sat", err_cnt, 16'hFFFF);
    cyc(1, 0, 16'h0000, 1, rnd64());
    cyc(1, 0, 16'h0000, 0, rnd64());
    chk("cnt_clr", err_cnt, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
